branch_pred_sched: RTL and testbench
====================================

# branch_pred_sched

Shared branch-prediction scheduler for the in-order branch unit. It holds a table of 2-bit hysteresis predictor counters and answers prediction requests from fetch. Each issued prediction is queued in order until execute resolves the branch with op/A/B. On resolve, the block compares operands, updates the counter and flags a mispredict.

## Interface
- ENTRIES, 4, predictor table entries (power of 2, ≥2)
- DEPTH, 4, in-flight prediction queue depth (power of 2, ≥2)
- IDX_W, $clog2(ENTRIES), table index width (derived)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch requests a prediction
- req_idx  in  IDX_W  table index of requesting branch
- req_ready  out  1  combinational; 1 when queue count < DEPTH
- pred_valid  out  1  registered; prediction available
- pred_taken  out  1  registered predicted direction
- res_valid  in  1  execute resolves oldest in-flight branch
- res_op  in  2  BEQ=00, BNE=01, BLT=10, BGE=11
- res_a, res_b  in  4 each  unsigned branch operands
- res_done  out  1  registered; resolution accepted
- res_taken  out  1  registered actual direction
- mispredict  out  1  registered; actual differs from queued prediction
- res_err  out  1  registered; res_valid with empty queue
- flush  in  1  discard all in-flight predictions
- count  out  $clog2(DEPTH)+1  registered queue occupancy

## Operation
- Counter FSM per entry, states 00/01/10/11. Taken: 00→01, 01→11, 10→11, 11→11. Not taken: 00→00, 01→00, 10→00, 11→10.
- Prediction = counter[1] (10/11 predict taken).
- Accept when req_valid && req_ready && !flush. Read table[req_idx], push {req_idx, prediction} to queue tail.
- Resolve when res_valid && count>0 && !flush. Pop head and evaluate taken:
  - BEQ: A==B
  - BNE: A!=B
  - BLT: A<B (unsigned)
  - BGE: A>=B (unsigned)
- On resolve, update table[head_idx] via the FSM. mispredict = taken ^ head_pred.
- res_valid with count==0 (no flush): res_err=1, table unchanged, res_done=0.
- flush: queue emptied (count→0), same-cycle req and res ignored (no pred_valid, res_done, res_err), table untouched.
- Simultaneous accept and resolve: push and pop together, count unchanged. Legal even at count==DEPTH? No — req_ready is low at full regardless of res_valid.
- Same-cycle accept and resolve on the same index: prediction uses the pre-update counter; no forwarding.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.

## Timing
- Reset: all counters 00, queue empty, count=0, req_ready=1. pred_valid, pred_taken, res_done, res_taken, mispredict and res_err are all 0.
- Prediction latency 1: accept at edge N → pred_valid/pred_taken valid for cycle N+1 only (single-cycle pulse).
- Resolution latency 1: res_done/res_taken/mispredict pulse in the cycle after res_valid. The updated counter is visible to a request in that same following cycle.
- One accept and one resolve per cycle maximum. Back-to-back throughput is 1/cycle.
- rst mid-operation overrides flush, req and res. It takes effect at the next edge with the reset values above; in-flight entries are lost.

## Structure
- Package branch_pkg holds:
  - op_e enum (BEQ/BNE/BLT/BGE)
  - ctr_t 2-bit counter typedef with state constants
  - function branch_taken(op, a, b)
  - function ctr_next(ctr, taken)
- Sub-module pred_fifo is a parameterised sync FIFO (push, pop, clear, count, head data, DEPTH), entry width IDX_W+1. The counter table and compare logic stay in the top level.

## Test plan
- Reset, then req idx 2 → next cycle pred_valid=1, pred_taken=0. Then resolve BEQ A=5,B=5 → res_taken=1, mispredict=1; table[2]=01.
- Idx 1 resolved taken twice (BGE 9,3) → counter 00→01→11. Next req idx 1 gives pred_taken=1; resolve BLT 9,3 → mispredict=1, counter 10.
- Four back-to-back reqs → count=4, req_ready=0. A fifth req is not accepted. Same-cycle req+res at full is rejected; the next cycle's req is accepted.
- res_valid on empty queue → res_err=1, res_done=0, all counters unchanged.
- With 3 in flight, flush with concurrent req and res → count=0, no pred_valid/res_done next cycle, table unchanged.
- Same-cycle req idx 0 and resolve of head idx 0 (counter 01, taken) → pred_taken=0 (old value). A req one cycle later gives pred_taken=1.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and helpers for the branch prediction scheduler
package branch_pkg;

  typedef enum logic [1:0] {
    BEQ = 2'b00,
    BNE = 2'b01,
    BLT = 2'b10,
    BGE = 2'b11
  } op_e;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic logic branch_taken(input op_e op, input logic [3:0] a, input logic [3:0] b);
    logic t;
    case (op)
      BEQ:     t = (a == b);
      BNE:     t = (a != b);
      BLT:     t = (a < b);
      default: t = (a >= b);
    endcase
    return t;
  endfunction

  // Hysteresis: a taken branch from weak-not-taken jumps straight to strong-taken,
  // and any not-taken outcome except from strong-taken collapses to strong-not-taken.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t n;
    if (taken) begin
      n = (ctr == CTR_SNT) ? CTR_WNT : CTR_ST;
    end else begin
      n = (ctr == CTR_ST) ? CTR_WT : CTR_SNT;
    end
    return n;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// rtl/pred_fifo.sv - in-order queue of issued predictions awaiting resolution
module pred_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/branch_pred_sched.sv
// rtl/branch_pred_sched.sv - 2-bit predictor table with in-order resolve queue
module branch_pred_sched
  import branch_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int DEPTH   = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [IDX_W-1:0]         req_idx,
  output logic                     req_ready,
  output logic                     pred_valid,
  output logic                     pred_taken,
  input  logic                     res_valid,
  input  logic [1:0]               res_op,
  input  logic [3:0]               res_a,
  input  logic [3:0]               res_b,
  output logic                     res_done,
  output logic                     res_taken,
  output logic                     mispredict,
  output logic                     res_err,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ctr_t             tbl [ENTRIES];
  logic             accept;
  logic             resolve;
  logic             taken;
  logic             req_pred;
  logic [IDX_W:0]   head_data;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;

  assign req_ready = (count < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready && !flush;
  assign resolve   = res_valid && (count != '0) && !flush;
  assign req_pred  = tbl[req_idx][1];
  assign taken     = branch_taken(op_e'(res_op), res_a, res_b);
  assign head_idx  = head_data[IDX_W:1];
  assign head_pred = head_data[0];

  pred_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({req_idx, req_pred}),
    .pop       (resolve),
    .clear     (flush),
    .head_data (head_data),
    .count     (count)
  );

  // A same-cycle request reads the pre-update counter; there is no forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= CTR_SNT;
    end else if (resolve) begin
      tbl[head_idx] <= ctr_next(tbl[head_idx], taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      res_done   <= 1'b0;
      res_taken  <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      pred_valid <= accept;
      pred_taken <= accept && req_pred;
      res_done   <= resolve;
      res_taken  <= resolve && taken;
      mispredict <= resolve && (taken ^ head_pred);
      res_err    <= res_valid && (count == '0) && !flush;
    end
  end

endmodule

// File: tb/tb_branch_pred_sched.sv
// tb/tb_branch_pred_sched.sv - scoreboard bench for branch_pred_sched
module tb_branch_pred_sched;

  logic       clk = 1'b0;
  logic       rst, req_valid, res_valid, flush;
  logic [1:0] req_idx, res_op;
  logic [3:0] res_a, res_b;
  logic       req_ready, pred_valid, pred_taken, res_done, res_taken, mispredict, res_err;
  logic [2:0] count;

  always #5 clk = ~clk;

  branch_pred_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .res_valid(res_valid), .res_op(res_op),
    .res_a(res_a), .res_b(res_b), .res_done(res_done), .res_taken(res_taken),
    .mispredict(mispredict), .res_err(res_err), .flush(flush), .count(count)
  );

  typedef struct { int idx; bit pred; } ent_t;
  typedef struct { bit pv; bit pt; bit rd; bit rt; bit mp; bit re; int cnt; } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   tbl[4];
  int   nxt_taken[4] = '{1, 3, 3, 3};
  int   nxt_ntaken[4] = '{0, 0, 0, 2};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit ref_taken(int op, int a, int b);
    case (op)
      0: return a == b;
      1: return a != b;
      2: return a < b;
      default: return a >= b;
    endcase
  endfunction

  // Drive one cycle of stimulus and record what the outputs must show after the edge.
  task automatic cyc(bit r, bit rqv, int ri, bit rsv, int op, int a, int b, bit f);
    exp_t e;
    int   pre;
    bit   acc, rsl, pred, t;
    ent_t h, n;
    @(negedge clk);
    rst = r; req_valid = rqv; req_idx = 2'(ri); res_valid = rsv;
    res_op = 2'(op); res_a = 4'(a); res_b = 4'(b); flush = f;
    e = '{default: 0};
    if (r) begin
      mq.delete();
      for (int i = 0; i < 4; i++) tbl[i] = 0;
    end else begin
      pre  = mq.size();
      acc  = rqv && pre < 4 && !f;
      rsl  = rsv && pre > 0 && !f;
      pred = (tbl[ri] >= 2);
      e.pv = acc;
      e.pt = acc && pred;
      e.re = rsv && pre == 0 && !f;
      if (rsl) begin
        h = mq.pop_front();
        t = ref_taken(op, a, b);
        e.rd = 1; e.rt = t; e.mp = t ^ h.pred;
        tbl[h.idx] = t ? nxt_taken[tbl[h.idx]] : nxt_ntaken[tbl[h.idx]];
      end
      if (acc) begin
        n.idx = ri; n.pred = pred;
        mq.push_back(n);
      end
      if (f) mq.delete();
    end
    e.cnt = mq.size();
    exp_q.push_back(e);
  endtask

  task automatic idle();                 cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic req(int i);             cyc(0, 1, i, 0, 0, 0, 0, 0); endtask
  task automatic res(int op, int a, int b); cyc(0, 0, 0, 1, op, a, b, 0); endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pred_valid", int'(pred_valid), int'(e.pv));
        if (e.pv) chk("pred_taken", int'(pred_taken), int'(e.pt));
        chk("res_done", int'(res_done), int'(e.rd));
        if (e.rd) begin
          chk("res_taken", int'(res_taken), int'(e.rt));
          chk("mispredict", int'(mispredict), int'(e.mp));
        end
        chk("res_err", int'(res_err), int'(e.re));
        chk("count", int'(count), e.cnt);
        chk("req_ready", int'(req_ready), int'(e.cnt < 4));
      end
    end
  end

  initial begin : stim
    rst = 1; req_valid = 0; req_idx = 0; res_valid = 0;
    res_op = 0; res_a = 0; res_b = 0; flush = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 1);
    idle();
    // first prediction and BEQ resolve
    req(2); idle(); res(0, 5, 5); idle();
    // idx 1 trained taken twice, then mispredicted by BLT
    req(1); req(1); res(3, 9, 3); res(3, 9, 3); req(1); res(2, 9, 3); idle();
    // fill to full, rejected reqs, then drain
    req(0); req(1); req(2); req(3); req(0);
    cyc(0, 1, 1, 1, 1, 2, 3, 0);
    req(2);
    res(1, 4, 4); res(2, 1, 8); res(3, 0, 15); res(0, 7, 7); idle();
    // resolve on empty queue
    res(0, 3, 3); idle();
    // flush with concurrent req and res
    req(3); req(3); req(1);
    cyc(0, 1, 2, 1, 0, 1, 1, 1);
    idle(); req(3); res(0, 0, 1); idle();
    // same-index req and resolve: old counter used
    req(0); res(0, 1, 1); req(0);
    cyc(0, 1, 0, 1, 0, 2, 2, 0);
    req(0); res(1, 1, 2); res(1, 3, 3); res(1, 3, 3); idle();
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 3),
          $urandom_range(0, 1) == 1, $urandom_range(0, 3), a, b, $urandom_range(0, 29) == 0);
    end
    idle(); idle();
    @(posedge clk); #2;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
